// File: rtl/baby_mem_sequencer.sv
// Store-RAM sequencer for the Manchester Baby: host LOAD over a byte port,
// RUN hands the 32x32 RAM to the core, DUMP streams it back to the host.
module baby_mem_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WDOG_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cmd_i,
  input  logic              cmd_valid_i,
  input  logic [7:0]        hbyte_i,
  input  logic              hbyte_valid_i,
  output logic [7:0]        hbyte_o,
  output logic              hbyte_valid_o,
  input  logic              hbyte_ack_i,
  input  logic [ADDR_W-1:0] baby_addr_i,
  input  logic [DATA_W-1:0] baby_data_i,
  input  logic              baby_we_i,
  input  logic              baby_stop_i,
  output logic [DATA_W-1:0] baby_data_o,
  output logic              baby_run_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        state_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DUMP = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   word_cnt;
  logic [1:0]          byte_cnt;
  logic [DATA_W-9:0]   ld_asm;
  logic [DATA_W-1:0]   dump_word;
  logic                dump_cap;
  logic [WDOG_W-1:0]   wdog;
  logic [WDOG_W-1:0]   wdog_inc;
  logic                abort, cmd_start, byte_last, word_last;
  logic                ld_fire, dump_adv, wdog_fire;

  assign abort     = cmd_valid_i && (cmd_i == 2'b00);
  assign cmd_start = (state_q == S_IDLE) && cmd_valid_i && (cmd_i != 2'b00);
  assign byte_last = (byte_cnt == 2'd3);
  assign word_last = &word_cnt;
  assign ld_fire   = (state_q == S_LOAD) && hbyte_valid_i && byte_last && !abort;
  assign dump_adv  = (state_q == S_DUMP) && hbyte_valid_o && hbyte_ack_i;
  assign wdog_inc  = wdog + WDOG_W'(1);
  // Fire on the cycle the count reaches all ones, so RUN lasts 2**WDOG_W-1 cycles.
  assign wdog_fire = &wdog_inc;

  assign state_o     = state_q;
  assign baby_data_o = mem_rdata_i;
  assign hbyte_o     = dump_word[{byte_cnt, 3'b000} +: 8];

  always_comb begin
    state_d     = state_q;
    baby_run_o  = 1'b0;
    mem_addr_o  = word_cnt;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          case (cmd_i)
            2'b01:   state_d = S_LOAD;
            2'b10:   state_d = S_RUN;
            2'b11:   state_d = S_DUMP;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        mem_we_o    = ld_fire;
        mem_wdata_o = {hbyte_i, ld_asm};
        if (ld_fire && word_last) state_d = S_IDLE;
      end
      S_RUN: begin
        baby_run_o  = 1'b1;
        mem_addr_o  = baby_addr_i;
        mem_wdata_o = baby_data_i;
        mem_we_o    = baby_we_i;
        if (baby_stop_i || wdog_fire) state_d = S_IDLE;
      end
      S_DUMP: begin
        // Issue the next read in the ack cycle itself to save a cycle per word.
        if (dump_adv && byte_last) begin
          mem_addr_o = word_cnt + ADDR_W'(1);
          if (word_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt      <= '0;
      byte_cnt      <= '0;
      ld_asm        <= '0;
      dump_word     <= '0;
      dump_cap      <= 1'b0;
      hbyte_valid_o <= 1'b0;
      wdog          <= '0;
      timeout_o     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            word_cnt      <= '0;
            byte_cnt      <= '0;
            wdog          <= '0;
            dump_cap      <= 1'b0;
            hbyte_valid_o <= 1'b0;
            if (cmd_i == 2'b10) timeout_o <= 1'b0;
          end
        end
        S_LOAD: begin
          if (hbyte_valid_i && !abort) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    ld_asm[7:0]   <= hbyte_i;
              2'd1:    ld_asm[15:8]  <= hbyte_i;
              2'd2:    ld_asm[23:16] <= hbyte_i;
              default: ;
            endcase
            if (byte_last) word_cnt <= word_cnt + ADDR_W'(1);
          end
        end
        S_RUN: begin
          wdog <= wdog_inc;
          if (baby_stop_i)    timeout_o <= 1'b0;
          else if (wdog_fire) timeout_o <= 1'b1;
        end
        S_DUMP: begin
          if (dump_cap) begin
            dump_word     <= mem_rdata_i;
            hbyte_valid_o <= 1'b1;
            dump_cap      <= 1'b0;
          end else if (!hbyte_valid_o) begin
            dump_cap <= 1'b1;
          end else if (hbyte_ack_i) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_last) begin
              hbyte_valid_o <= 1'b0;
              if (!word_last) begin
                word_cnt <= word_cnt + ADDR_W'(1);
                dump_cap <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
      if (abort) begin
        hbyte_valid_o <= 1'b0;
        dump_cap      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baby_mem_sequencer.sv
// Directed bench for baby_mem_sequencer with a behavioural 32x32 sync RAM.
module tb_baby_mem_sequencer;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WDOG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        cmd_i;
  logic              cmd_valid_i;
  logic [7:0]        hbyte_i;
  logic              hbyte_valid_i;
  logic [7:0]        hbyte_o;
  logic              hbyte_valid_o;
  logic              hbyte_ack_i;
  logic [ADDR_W-1:0] baby_addr_i;
  logic [DATA_W-1:0] baby_data_i;
  logic              baby_we_i;
  logic              baby_stop_i;
  logic [DATA_W-1:0] baby_data_o;
  logic              baby_run_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic [1:0]        state_o;
  logic              timeout_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned wr_count = 0;
  int unsigned bad_we   = 0;
  int unsigned wc0;
  logic [7:0]  expb [128];
  logic [31:0] ram  [32];

  always #5 clk = ~clk;

  baby_mem_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .WDOG_W (WDOG_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_i         (cmd_i),
    .cmd_valid_i   (cmd_valid_i),
    .hbyte_i       (hbyte_i),
    .hbyte_valid_i (hbyte_valid_i),
    .hbyte_o       (hbyte_o),
    .hbyte_valid_o (hbyte_valid_o),
    .hbyte_ack_i   (hbyte_ack_i),
    .baby_addr_i   (baby_addr_i),
    .baby_data_i   (baby_data_i),
    .baby_we_i     (baby_we_i),
    .baby_stop_i   (baby_stop_i),
    .baby_data_o   (baby_data_o),
    .baby_run_o    (baby_run_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_we_o      (mem_we_o),
    .mem_rdata_i   (mem_rdata_i),
    .state_o       (state_o),
    .timeout_o     (timeout_o)
  );

  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  always @(negedge clk) begin
    if (rst_n && mem_we_o) begin
      wr_count++;
      if (state_o == 2'b00 || state_o == 2'b11) bad_we++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] c);
    cmd_i       = c;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    cmd_i       = 2'b00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    hbyte_i       = b;
    hbyte_valid_i = 1'b1;
    tick();
    hbyte_valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    int unsigned n = 0;
    while (hbyte_valid_o !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("dump_valid_wait", 32'(hbyte_valid_o), 32'd1);
  endtask

  task automatic get_byte(input int k);
    wait_valid();
    chk($sformatf("dump_byte%0d", k), 32'(hbyte_o), 32'(expb[k]));
    hbyte_ack_i = 1'b1;
    tick();
    hbyte_ack_i = 1'b0;
  endtask

  task automatic dump_all();
    do_cmd(2'b11);
    for (int k = 0; k < 128; k++) get_byte(k);
    chk("dump_end_state", 32'(state_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; cmd_i = 2'b00; cmd_valid_i = 1'b0; hbyte_i = 8'h00;
    hbyte_valid_i = 1'b0; hbyte_ack_i = 1'b0; baby_addr_i = '0;
    baby_data_i = '0; baby_we_i = 1'b0; baby_stop_i = 1'b0;
    for (int k = 0; k < 128; k++) expb[k] = 8'((k * 13 + 5) & 255);
    expb[0] = 8'h78; expb[1] = 8'h56; expb[2] = 8'h34; expb[3] = 8'h12;

    // Reset
    tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_run", 32'(baby_run_o), 32'd0);
    chk("rst_hvalid", 32'(hbyte_valid_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_hbyte", 32'(hbyte_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Load 128 bytes
    do_cmd(2'b01);
    chk("load_state", 32'(state_o), 32'd1);
    for (int k = 0; k < 128; k++) begin
      send_byte(expb[k]);
      if (k == 3) begin
        chk("load_wr_word0", wr_count, 32'd1);
        chk("load_ram0", ram[0], 32'h12345678);
      end
    end
    chk("load_wr_total", wr_count, 32'd32);
    chk("load_end_state", 32'(state_o), 32'd0);
    chk("load_ram31", ram[31], {expb[127], expb[126], expb[125], expb[124]});
    send_byte(8'hFF);
    chk("idle_byte_ignored", wr_count, 32'd32);

    // Dump with latency, ack-gap and hold checks
    do_cmd(2'b11);
    chk("dump_state", 32'(state_o), 32'd3);
    chk("dump_lat0", 32'(hbyte_valid_o), 32'd0);
    tick();
    chk("dump_lat1", 32'(hbyte_valid_o), 32'd0);
    tick();
    chk("dump_lat2", 32'(hbyte_valid_o), 32'd1);
    for (int k = 0; k < 128; k++) begin
      wait_valid();
      if (k == 5) begin
        repeat (5) begin
          chk("hold_stable", 32'(hbyte_o), 32'(expb[5]));
          chk("hold_valid", 32'(hbyte_valid_o), 32'd1);
          tick();
        end
      end
      chk($sformatf("dump_byte%0d", k), 32'(hbyte_o), 32'(expb[k]));
      hbyte_ack_i = 1'b1;
      tick();
      if (k == 3) begin
        chk("word_gap0", 32'(hbyte_valid_o), 32'd0);
        tick();
        chk("word_gap1", 32'(hbyte_valid_o), 32'd1);
      end
      hbyte_ack_i = 1'b0;
    end
    chk("dump_end_state", 32'(state_o), 32'd0);

    // Run: core write then stop
    baby_we_i = 1'b1; baby_addr_i = 5'd7; baby_data_i = 32'hDEADBEEF;
    #1;
    chk("idle_baby_we_ignored", 32'(mem_we_o), 32'd0);
    baby_we_i = 1'b0;
    do_cmd(2'b10);
    chk("run_state", 32'(state_o), 32'd2);
    chk("run_release", 32'(baby_run_o), 32'd1);
    baby_we_i = 1'b1;
    #1;
    chk("run_we", 32'(mem_we_o), 32'd1);
    chk("run_addr", 32'(mem_addr_o), 32'd7);
    chk("run_wdata", mem_wdata_o, 32'hDEADBEEF);
    tick();
    baby_we_i = 1'b0;
    baby_stop_i = 1'b1;
    chk("run_before_stop", 32'(baby_run_o), 32'd1);
    tick();
    baby_stop_i = 1'b0;
    chk("stop_run_low", 32'(baby_run_o), 32'd0);
    chk("stop_state", 32'(state_o), 32'd0);
    chk("stop_timeout", 32'(timeout_o), 32'd0);
    chk("ram7", ram[7], 32'hDEADBEEF);
    expb[28] = 8'hEF; expb[29] = 8'hBE; expb[30] = 8'hAD; expb[31] = 8'hDE;
    dump_all();

    // Watchdog timeout after 15 RUN cycles
    do_cmd(2'b10);
    repeat (14) tick();
    chk("wdog_cycle15_run", 32'(state_o), 32'd2);
    tick();
    chk("wdog_state", 32'(state_o), 32'd0);
    chk("wdog_timeout", 32'(timeout_o), 32'd1);
    chk("wdog_run_low", 32'(baby_run_o), 32'd0);
    do_cmd(2'b10);
    chk("timeout_cleared", 32'(timeout_o), 32'd0);
    baby_stop_i = 1'b1;
    tick();
    baby_stop_i = 1'b0;
    chk("stop2_state", 32'(state_o), 32'd0);
    do_cmd(2'b10);
    repeat (14) tick();
    baby_stop_i = 1'b1;
    tick();
    baby_stop_i = 1'b0;
    chk("stop_wins_state", 32'(state_o), 32'd0);
    chk("stop_wins_timeout", 32'(timeout_o), 32'd0);

    // Abort mid-load after 2 bytes of word 3
    wc0 = wr_count;
    do_cmd(2'b01);
    for (int k = 0; k < 14; k++) send_byte(8'(8'hA0 + k));
    do_cmd(2'b00);
    chk("abort_load_state", 32'(state_o), 32'd0);
    chk("abort_load_we", 32'(mem_we_o), 32'd0);
    chk("abort_load_writes", wr_count, wc0 + 32'd3);
    for (int k = 0; k < 12; k++) expb[k] = 8'(8'hA0 + k);
    send_byte(8'h55);
    chk("abort_no_stray_we", wr_count, wc0 + 32'd3);
    chk("abort_ram3_kept", ram[3], {expb[15], expb[14], expb[13], expb[12]});

    // Abort mid-dump; load command while busy is ignored
    do_cmd(2'b11);
    for (int k = 0; k < 13; k++) get_byte(k);
    wait_valid();
    chk("mid_dump_byte13", 32'(hbyte_o), 32'(expb[13]));
    do_cmd(2'b01);
    chk("busy_cmd_ignored", 32'(state_o), 32'd3);
    chk("busy_cmd_valid", 32'(hbyte_valid_o), 32'd1);
    chk("busy_cmd_byte", 32'(hbyte_o), 32'(expb[13]));
    do_cmd(2'b00);
    chk("abort_dump_state", 32'(state_o), 32'd0);
    chk("abort_dump_valid", 32'(hbyte_valid_o), 32'd0);
    chk("abort_dump_run", 32'(baby_run_o), 32'd0);

    chk("no_we_idle_dump", bad_we, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
